// File: rtl/dose_scheduler.sv
// Dose scheduler: counts minutes to each dose, handshakes with the motor stage, then tracks patient ack.
// All outputs registered, 1 cycle after the sampled input; dispense_req holds until dispense_done.
module dose_scheduler #(
  parameter int INTERVAL_W  = 10,
  parameter int DOSE_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  minutePulse,
  input  logic                  enable,
  input  logic                  cfg_load,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic [DOSE_W-1:0]     cfg_doses,
  input  logic                  dispense_done,
  input  logic                  dose_ack,
  output logic                  dispense_req,
  output logic                  alarm,
  output logic [INTERVAL_W-1:0] minutes_left,
  output logic [DOSE_W-1:0]     doses_given,
  output logic [DOSE_W-1:0]     missed_count,
  output logic                  course_done,
  output logic                  overrun
);

  localparam int AW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COUNT, REQUEST, WAIT_ACK, DONE} state_t;

  state_t                state, state_nxt;
  logic [INTERVAL_W-1:0] interval_q, interval_nxt;
  logic [DOSE_W-1:0]     target_q, target_nxt;
  logic [AW-1:0]         ack_timer, ack_timer_nxt;
  logic [INTERVAL_W-1:0] minutes_left_nxt;
  logic [DOSE_W-1:0]     doses_given_nxt, missed_count_nxt;
  logic                  dispense_req_nxt, alarm_nxt, course_done_nxt, overrun_nxt;
  logic                  tick, expire, timeout;

  // Countdown runs only under enable in COUNT, but unconditionally while a dose is in flight.
  assign tick    = minutePulse & (((state == COUNT) & enable) | (state == REQUEST) | (state == WAIT_ACK));
  assign expire  = tick & (minutes_left <= INTERVAL_W'(1));
  assign timeout = minutePulse & (state == WAIT_ACK) & (ack_timer == AW'(1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      interval_q   <= INTERVAL_W'(1);
      target_q     <= '0;
      ack_timer    <= '0;
      minutes_left <= '0;
      doses_given  <= '0;
      missed_count <= '0;
      dispense_req <= 1'b0;
      alarm        <= 1'b0;
      course_done  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      interval_q   <= interval_nxt;
      target_q     <= target_nxt;
      ack_timer    <= ack_timer_nxt;
      minutes_left <= minutes_left_nxt;
      doses_given  <= doses_given_nxt;
      missed_count <= missed_count_nxt;
      dispense_req <= dispense_req_nxt;
      alarm        <= alarm_nxt;
      course_done  <= course_done_nxt;
      overrun      <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    interval_nxt     = interval_q;
    target_nxt       = target_q;
    ack_timer_nxt    = ack_timer;
    minutes_left_nxt = minutes_left;
    doses_given_nxt  = doses_given;
    missed_count_nxt = missed_count;
    dispense_req_nxt = dispense_req;
    alarm_nxt        = alarm;
    course_done_nxt  = course_done;
    overrun_nxt      = overrun;

    if (cfg_load) begin
      interval_nxt     = (cfg_interval == '0) ? INTERVAL_W'(1) : cfg_interval;
      target_nxt       = cfg_doses;
      ack_timer_nxt    = '0;
      minutes_left_nxt = '0;
      doses_given_nxt  = '0;
      missed_count_nxt = '0;
      dispense_req_nxt = 1'b0;
      alarm_nxt        = 1'b0;
      course_done_nxt  = 1'b0;
      overrun_nxt      = 1'b0;
      state_nxt        = IDLE;
    end else begin
      if (tick)
        minutes_left_nxt = expire ? interval_q : minutes_left - 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            minutes_left_nxt = interval_q;
            state_nxt        = COUNT;
          end
        end
        COUNT: begin
          if (expire) begin
            dispense_req_nxt = 1'b1;
            state_nxt        = REQUEST;
          end
        end
        REQUEST: begin
          // A second expiry while the motor is busy is flagged, not queued.
          if (expire)
            overrun_nxt = 1'b1;
          if (dispense_done) begin
            doses_given_nxt  = (doses_given == '1) ? doses_given : doses_given + 1'b1;
            dispense_req_nxt = 1'b0;
            alarm_nxt        = 1'b1;
            ack_timer_nxt    = AW'(ACK_TIMEOUT);
            state_nxt        = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (minutePulse && ack_timer != '0)
            ack_timer_nxt = ack_timer - 1'b1;
          if (dose_ack | timeout | expire) begin
            if (!dose_ack)
              missed_count_nxt = (missed_count == '1) ? missed_count : missed_count + 1'b1;
            alarm_nxt = expire & ~dose_ack;
            if (target_q != '0 && doses_given == target_q) begin
              minutes_left_nxt = '0;
              alarm_nxt        = 1'b0;
              course_done_nxt  = 1'b1;
              state_nxt        = DONE;
            end else if (expire) begin
              dispense_req_nxt = 1'b1;
              state_nxt        = REQUEST;
            end else begin
              state_nxt = COUNT;
            end
          end
        end
        DONE: minutes_left_nxt = '0;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
